// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter: FSM states and line levels.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Counts BIT_CYCLES clocks per serial bit; o_bit_end marks the last cycle of a bit.
module bit_timer #(
  parameter int BIT_CYCLES = 4,
  parameter int CW         = $clog2(BIT_CYCLES) + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_clear,
  output logic          o_bit_end,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count <= '0;
    end else if (i_clear || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_bit_end = (r_count == LAST);
  assign o_count   = r_count;

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, WIDTH data bits LSB first, stop bit; all outputs registered.
// Handshake: a word is accepted on a rising edge where LOAD=1 and READY=1; LOAD at other times is dropped.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             TX,
  output logic             BUSY,
  output logic             DONE,
  output state_e           DBG_STATE
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = (BIT_CYCLES > 1) ? CW'(BIT_CYCLES - 2) : '0;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [IW-1:0]    r_idx;
  logic             r_ready;
  logic             r_busy;
  logic             r_tx;
  logic             r_done;
  logic             w_accept;
  logic             w_bit_end;
  logic             w_timer_clear;
  logic             w_done_nxt;
  logic [CW-1:0]    w_count;

  assign w_accept      = LOAD && r_ready;
  assign w_timer_clear = (r_state == IDLE);

  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .CW         (CW)
  ) u_bit_timer (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_clear   (w_timer_clear),
    .o_bit_end (w_bit_end),
    .o_count   (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = START;
      START:   if (w_bit_end) w_state_nxt = DATA;
      DATA:    if (w_bit_end && (r_idx == LAST_IDX)) w_state_nxt = STOP;
      STOP:    if (w_bit_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // DONE is registered, so it is raised one edge ahead of the final stop cycle.
  always_comb begin
    w_done_nxt = 1'b0;
    if (BIT_CYCLES == 1) begin
      w_done_nxt = (w_state_nxt == STOP);
    end else begin
      w_done_nxt = (r_state == STOP) && (w_count == PRE_LAST);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_tx    <= IDLE_LEVEL;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= DIN;
            r_idx   <= '0;
            r_tx    <= START_LEVEL;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= '0;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_idx == LAST_IDX) begin
              r_tx <= STOP_LEVEL;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + IW'(1);
            end
          end
        end
        STOP: begin
          if (w_bit_end) r_tx <= IDLE_LEVEL;
        end
        default: r_tx <= IDLE_LEVEL;
      endcase
    end
  end

  assign READY     = r_ready;
  assign BUSY      = r_busy;
  assign TX        = r_tx;
  assign DONE      = r_done;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: default instance (8 bits, 4 cycles/bit) and a 4-bit, 1 cycle/bit instance.
`timescale 1ns/1ps
module tb_serial_tx;
  import serial_pkg::*;

  localparam int W0 = 8;
  localparam int B0 = 4;
  localparam int W1 = 4;
  localparam int B1 = 1;
  localparam int F0 = (W0 + 2) * B0;
  localparam int F1 = (W1 + 2) * B1;
  localparam int M_PULSE = 0;
  localparam int M_HOLD  = 1;
  localparam int M_NOISE = 2;

  logic       CLK;
  logic       RESET;
  logic [7:0] din0;
  logic       load0, ready0, tx0, busy0, done0;
  state_e     dbg0;
  logic [3:0] din1;
  logic       load1, ready1, tx1, busy1, done1;
  state_e     dbg1;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  serial_tx dut0 (
    .CLK(CLK), .RESET(RESET), .DIN(din0), .LOAD(load0), .READY(ready0),
    .TX(tx0), .BUSY(busy0), .DONE(done0), .DBG_STATE(dbg0)
  );

  serial_tx #(.WIDTH(W1), .BIT_CYCLES(B1)) dut1 (
    .CLK(CLK), .RESET(RESET), .DIN(din1), .LOAD(load1), .READY(ready1),
    .TX(tx1), .BUSY(busy1), .DONE(done1), .DBG_STATE(dbg1)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: line level for every cycle of a frame, from the frame rules.
  task automatic build_frame(input logic [31:0] word, input int w, input int b);
    exp_q.delete();
    for (int i = 0; i < b; i++) exp_q.push_back(1'b0);
    for (int j = 0; j < w; j++)
      for (int i = 0; i < b; i++) exp_q.push_back(word[j]);
    for (int i = 0; i < b; i++) exp_q.push_back(1'b1);
  endtask

  task automatic main_frame(input logic [7:0] word, input int mode, input int reset_cyc);
    logic [9:0] seen;
    logic       e;
    seen  = '0;
    din0  = word;
    load0 = 1'b1;
    tick();
    build_frame({24'd0, word}, W0, B0);
    if (mode != M_HOLD) load0 = 1'b0;
    for (int k = 0; k < F0; k++) begin
      e = exp_q.pop_front();
      check("main_tx", {31'd0, tx0}, {31'd0, e});
      check("main_done", {31'd0, done0}, {31'd0, (k == F0 - 1)});
      check("main_ready_busy", {30'd0, ready0, busy0}, 32'd1);
      if (k % B0 == 0) seen[k / B0] = tx0;
      if (mode == M_NOISE) begin
        if (k >= 4 && k < 30) begin
          din0  = (k % 3 == 0) ? 8'h3C : 8'($urandom);
          load0 = 1'($urandom_range(0, 1));
        end else begin
          load0 = 1'b0;
        end
      end
      if (reset_cyc != 0 && k + 1 == reset_cyc) begin
        RESET = 1'b1;
        #1;
        check("reset_now", {28'd0, tx0, ready0, busy0, done0}, 32'hC);
        tick();
        check("reset_hold", {28'd0, tx0, ready0, busy0, done0}, 32'hC);
        RESET = 1'b0;
        tick();
        check("reset_after", {28'd0, tx0, ready0, busy0, done0}, 32'hC);
        return;
      end
      tick();
    end
    check("main_end", {28'd0, tx0, ready0, busy0, done0}, 32'hC);
    if (word == 8'hA5 && mode == M_PULSE) check("a5_pattern", {22'd0, seen}, 32'h34A);
    if (mode == M_NOISE) begin
      tick();
      check("no_second_frame", {29'd0, tx0, ready0, busy0}, 32'h6);
    end
  endtask

  task automatic small_frame(input logic [3:0] word, input bit noise);
    logic [5:0] seen;
    logic       e;
    seen  = '0;
    din1  = word;
    load1 = 1'b1;
    tick();
    build_frame({28'd0, word}, W1, B1);
    load1 = 1'b0;
    for (int k = 0; k < F1; k++) begin
      e = exp_q.pop_front();
      check("small_tx", {31'd0, tx1}, {31'd0, e});
      check("small_done", {31'd0, done1}, {31'd0, (k == F1 - 1)});
      check("small_ready_busy", {30'd0, ready1, busy1}, 32'd1);
      seen[k] = tx1;
      if (noise && k < F1 - 1) begin
        din1  = 4'($urandom);
        load1 = 1'($urandom_range(0, 1));
      end else begin
        load1 = 1'b0;
      end
      tick();
    end
    check("small_end", {28'd0, tx1, ready1, busy1, done1}, 32'hC);
    if (word == 4'b1010) check("small_pattern", {26'd0, seen}, 32'h34);
  endtask

  initial begin
    RESET = 1'b1;
    din0  = 8'hA5;
    load0 = 1'b1;
    din1  = 4'hF;
    load1 = 1'b1;
    #1;
    check("reset_async_0", {28'd0, tx0, ready0, busy0, done0}, 32'hC);
    repeat (3) tick();
    check("reset_load_ignored_0", {28'd0, tx0, ready0, busy0, done0}, 32'hC);
    check("reset_load_ignored_1", {28'd0, tx1, ready1, busy1, done1}, 32'hC);
    check("reset_state", {30'd0, dbg0}, {30'd0, IDLE});
    load0 = 1'b0;
    load1 = 1'b0;
    RESET = 1'b0;
    tick();
    check("idle_after_reset", {28'd0, tx0, ready0, busy0, done0}, 32'hC);

    main_frame(8'hA5, M_PULSE, 0);

    main_frame(8'h00, M_HOLD, 0);
    main_frame(8'hFF, M_HOLD, 0);
    load0 = 1'b0;
    tick();
    check("hold_release_idle", {29'd0, tx0, ready0, busy0}, 32'h6);

    main_frame(8'hA5, M_NOISE, 0);
    main_frame(8'hA5, M_PULSE, 17);
    main_frame(8'h81, M_PULSE, 0);

    small_frame(4'b1010, 1'b0);

    for (int n = 0; n < 6; n++) begin
      main_frame(8'($urandom), ($urandom_range(0, 1) == 1) ? M_NOISE : M_PULSE, 0);
    end
    main_frame(8'($urandom), M_PULSE, int'($urandom_range(1, F0 - 1)));
    main_frame(8'($urandom), M_PULSE, 0);
    for (int n = 0; n < 8; n++) begin
      small_frame(4'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
